// File: rtl/altera_up_programmable_clock_generator.sv
// Programmable slow-clock generator: divides clk by 2*active_half and emits
// registered edge and mid-level strobes aligned with the new_clk level they describe.
module altera_up_programmable_clock_generator #(
    parameter int CB           = 10,
    parameter int DEFAULT_HALF = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_clk,
    input  logic [CB-1:0] half_period,
    input  logic          load_period,
    input  logic          restart,
    output logic          new_clk,
    output logic          rising_edge,
    output logic          falling_edge,
    output logic          middle_of_high_level,
    output logic          middle_of_low_level,
    output logic [CB-1:0] active_half
);

    localparam logic [CB-1:0] DEF_HALF = CB'(DEFAULT_HALF);
    localparam logic [CB-1:0] ONE      = CB'(1);

    logic [CB-1:0] cnt, cnt_nxt;
    logic [CB-1:0] pending_half, pending_half_nxt;
    logic          pending_valid, pending_valid_nxt;
    logic [CB-1:0] active_half_nxt;
    logic [CB-1:0] mid;
    logic          new_clk_nxt;
    logic          rise_nxt, fall_nxt, mid_hi_nxt, mid_lo_nxt;

    always_comb begin
        cnt_nxt           = cnt;
        new_clk_nxt       = new_clk;
        active_half_nxt   = active_half;
        pending_half_nxt  = pending_half;
        pending_valid_nxt = pending_valid;
        rise_nxt          = 1'b0;
        fall_nxt          = 1'b0;
        mid_hi_nxt        = 1'b0;
        mid_lo_nxt        = 1'b0;
        mid               = '0;

        if (restart) begin
            cnt_nxt     = '0;
            new_clk_nxt = 1'b0;
            if (pending_valid) begin
                active_half_nxt   = pending_half;
                pending_valid_nxt = 1'b0;
            end
        end else if (enable_clk) begin
            if (cnt == active_half - ONE) begin
                // Period reload only at a level boundary, so no runt phase.
                cnt_nxt     = '0;
                new_clk_nxt = ~new_clk;
                rise_nxt    = ~new_clk;
                fall_nxt    = new_clk;
                if (pending_valid) begin
                    active_half_nxt   = pending_half;
                    pending_valid_nxt = 1'b0;
                end
            end else begin
                cnt_nxt = cnt + ONE;
            end
            mid        = active_half_nxt >> 1;
            mid_hi_nxt = (cnt_nxt == mid) &&  new_clk_nxt;
            mid_lo_nxt = (cnt_nxt == mid) && !new_clk_nxt;
        end

        // A load in the same cycle as an apply becomes the next pending value.
        if (load_period) begin
            pending_half_nxt  = (half_period == '0) ? ONE : half_period;
            pending_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt                  <= '0;
            new_clk              <= 1'b0;
            active_half          <= DEF_HALF;
            pending_half         <= DEF_HALF;
            pending_valid        <= 1'b0;
            rising_edge          <= 1'b0;
            falling_edge         <= 1'b0;
            middle_of_high_level <= 1'b0;
            middle_of_low_level  <= 1'b0;
        end else begin
            cnt                  <= cnt_nxt;
            new_clk              <= new_clk_nxt;
            active_half          <= active_half_nxt;
            pending_half         <= pending_half_nxt;
            pending_valid        <= pending_valid_nxt;
            rising_edge          <= rise_nxt;
            falling_edge         <= fall_nxt;
            middle_of_high_level <= mid_hi_nxt;
            middle_of_low_level  <= mid_lo_nxt;
        end
    end

endmodule

// File: tb/tb_altera_up_programmable_clock_generator.sv
// Bench for the programmable clock generator: directed scenarios plus random
// traffic, every cycle compared against an integer phase-position model.
module tb_altera_up_programmable_clock_generator;

    localparam int CB = 4;
    localparam int DH = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable_clk = 1'b0;
    logic [CB-1:0] half_period = '0;
    logic          load_period = 1'b0;
    logic          restart = 1'b0;
    logic          new_clk, rising_edge, falling_edge;
    logic          middle_of_high_level, middle_of_low_level;
    logic [CB-1:0] active_half;

    altera_up_programmable_clock_generator #(.CB(CB), .DEFAULT_HALF(DH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable_clk           (enable_clk),
        .half_period          (half_period),
        .load_period          (load_period),
        .restart              (restart),
        .new_clk              (new_clk),
        .rising_edge          (rising_edge),
        .falling_edge         (falling_edge),
        .middle_of_high_level (middle_of_high_level),
        .middle_of_low_level  (middle_of_low_level),
        .active_half          (active_half)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: position within the current half-period, level, and period bookkeeping.
    int m_pos, m_lvl, m_act, m_pend, m_pv;
    int e_rise, e_fall, e_mh, e_ml;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_lvl = 0; m_act = DH; m_pend = DH; m_pv = 0;
        e_rise = 0; e_fall = 0; e_mh = 0; e_ml = 0;
    endtask

    task automatic model_step(input int en, input int ld, input int hp, input int rs);
        e_rise = 0; e_fall = 0; e_mh = 0; e_ml = 0;
        if (rs != 0) begin
            m_pos = 0;
            m_lvl = 0;
            if (m_pv != 0) begin m_act = m_pend; m_pv = 0; end
        end else if (en != 0) begin
            m_pos = m_pos + 1;
            if (m_pos >= m_act) begin
                m_pos  = 0;
                m_lvl  = 1 - m_lvl;
                e_rise = m_lvl;
                e_fall = 1 - m_lvl;
                if (m_pv != 0) begin m_act = m_pend; m_pv = 0; end
            end
            e_mh = (m_pos == m_act / 2 && m_lvl == 1) ? 1 : 0;
            e_ml = (m_pos == m_act / 2 && m_lvl == 0) ? 1 : 0;
        end
        if (ld != 0) begin
            m_pend = (hp == 0) ? 1 : hp;
            m_pv   = 1;
        end
    endtask

    task automatic compare_all();
        chk("new_clk", int'(new_clk), m_lvl);
        chk("rising_edge", int'(rising_edge), e_rise);
        chk("falling_edge", int'(falling_edge), e_fall);
        chk("mid_high", int'(middle_of_high_level), e_mh);
        chk("mid_low", int'(middle_of_low_level), e_ml);
        chk("active_half", int'(active_half), m_act);
    endtask

    task automatic step(input int en, input int ld, input int hp, input int rs);
        enable_clk  = (en != 0);
        load_period = (ld != 0);
        half_period = CB'(hp);
        restart     = (rs != 0);
        @(posedge clk);
        model_step(en, ld, hp, rs);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable_clk = 1'b0; load_period = 1'b0; restart = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    logic [11:0] pat;

    initial begin
        // Default sequence: 000111000111 with H=3
        do_reset();
        pat[11] = new_clk;
        for (int i = 10; i >= 0; i--) begin
            step(1, 0, 0, 0);
            pat[i] = new_clk;
        end
        chk("default_pattern", int'(pat), int'(12'b000111000111));

        // Reload mid high phase: takes effect at the falling edge of cycle 6
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 0);
        step(1, 1, 5, 0);
        step(1, 0, 0, 0);
        chk("reload_fall", int'(falling_edge), 1);
        chk("reload_act", int'(active_half), 5);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);

        // H=0 then H=1 via load+restart: toggle every cycle
        step(1, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("h0_act", int'(active_half), 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            chk("h1_strobe", int'(rising_edge | falling_edge), 1);
            chk("h1_mid", int'(middle_of_high_level | middle_of_low_level), 1);
        end

        // Stall right after a rising edge
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("stall_rise", int'(rising_edge), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("stall_hold", int'(new_clk), 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

        // Restart while high with a pending load of 2
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 1, 2, 0);
        step(1, 0, 0, 1);
        chk("rst_act", int'(active_half), 2);
        chk("rst_nofall", int'(falling_edge), 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);

        // Async reset between clock edges
        step(1, 1, 7, 0);
        step(1, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_clk", int'(new_clk), 0);
        chk("async_act", int'(active_half), DH);
        chk("async_rise", int'(rising_edge), 0);
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int en, ld, hp, rs;
            en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            ld = ($urandom_range(0, 19) == 0) ? 1 : 0;
            hp = int'($urandom_range(0, 15));
            rs = ($urandom_range(0, 39) == 0) ? 1 : 0;
            step(en, ld, hp, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/altera_up_programmable_clock_generator.md
Name: altera_up_programmable_clock_generator

Overview:
- Runtime-programmable slow-clock generator: divides clk by 2*H, where H is a half-period count loaded through a port, with a parameter default.
- Emits the divided level plus single-cycle event strobes (rising/falling edge, middle of high/low level) for audio/video/serial-interface timing.
- Adds glitch-free period reload, synchronous phase restart and an enable-gated advance.

Parameters:
- CB, 10, counter/half-period width in bits (2..16).
- DEFAULT_HALF, 512, half-period in effect after reset (1..2^CB-1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable_clk  input  1  advance counter this cycle
- half_period  input  CB  requested half-period H; 0 is treated as 1
- load_period  input  1  capture half_period into the pending register
- restart  input  1  synchronous phase restart
- new_clk  output  1  divided clock level
- rising_edge  output  1  one-cycle strobe, new_clk just became 1
- falling_edge  output  1  one-cycle strobe, new_clk just became 0
- middle_of_high_level  output  1  one-cycle strobe at mid high phase
- middle_of_low_level  output  1  one-cycle strobe at mid low phase
- active_half  output  CB  half-period currently in effect

Behaviour:
- Reset (async, active-high): cnt=0, new_clk=0, all strobes 0, active_half=DEFAULT_HALF, pending register empty.
- State: cnt[CB-1:0], new_clk, active_half, pending_half, pending_valid.
- Load:
  - load_period=1 captures max(half_period,1) into pending_half and sets pending_valid.
  - A later load before it is applied overwrites the earlier one.
- Advance (enable_clk=1, restart=0):
  - If cnt == active_half-1 (wrap): cnt<=0; new_clk<=~new_clk; rising_edge<=~new_clk; falling_edge<=new_clk.
  - On wrap, if pending_valid: active_half<=pending_half and pending_valid<=0. The new period therefore starts on a level boundary; no runt phase.
  - Otherwise: cnt<=cnt+1 and no edge strobe.
- Mid strobes, evaluated on the post-update state:
  - mid = active_half_next>>1.
  - middle_of_high_level<=1 iff cnt_next==mid and new_clk_next==1.
  - middle_of_low_level<=1 iff cnt_next==mid and new_clk_next==0.
  - For H=1, mid=0, so the mid strobe coincides with the edge strobe; this is legal.
- Stall (enable_clk=0): cnt and new_clk hold; all four strobes 0 next cycle. Strobes fire only on entry, never repeat while stalled.
- Restart (restart=1, dominates enable_clk):
  - cnt<=0, new_clk<=0, all strobes 0.
  - If pending_valid, pending is applied immediately.
  - A load_period in the same cycle is captured as pending and applied at the next wrap, not at this restart.
- Latency: strobes are registered and valid in the same cycle as the new_clk/cnt value they describe.
- Output period with enable_clk tied high: 2*active_half clk cycles; duty 50%.
- active_half changes only at wrap or restart.
- Counter never exceeds active_half-1. If restart loads a smaller H while cnt is larger, cnt is already 0, so no overflow path exists.

Test Plan:
- Reset/default, CB=4, DEFAULT_HALF=3, enable high -> new_clk 000111000111...; rising_edge on cycles 3,9; falling_edge on 6,12; mid_high at cnt=1 of each high phase (cycles 4,10); mid_low on cycles 1,7.
- Reload mid-phase: at cycle 4 pulse load_period with half_period=5 -> current high phase still lasts 3 cycles; active_half becomes 5 at the falling edge (cycle 6); next low phase is 5 cycles; pending_valid clears.
- half_period=0 then 1 via load+restart -> both behave as H=1: new_clk toggles every cycle, every cycle carries an edge strobe plus a mid strobe.
- Stall: drop enable_clk for 4 cycles right after a rising_edge -> new_clk holds 1, no strobes repeat, phase resumes with the remaining count intact.
- Restart while new_clk=1 and a load of 2 is pending -> next cycle new_clk=0, cnt=0, active_half=2, no falling_edge strobe.
- Async reset asserted mid-phase between clock edges -> outputs clear immediately without a clock edge; after release, default sequence restarts from cycle 0.
